mem_readout_seq: RTL

- Read sequencer that sits directly upstream of the 24:1 registered memory-data mux.
- Once per BX it latches the entry counts of the NMEM input memories and walks all non-empty memories in ascending index order.
- For each entry it issues a broadcast read address, plus a mux select delayed to line up with memory read data.
- It also produces a valid/BX tag aligned with the mux's registered output stream, and enforces a per-BX read budget.

---
 rtl/mem_readout_seq.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_readout_seq.sv
// Per-BX read sequencer feeding the 24:1 registered memory-data mux.
// Define MEM_READOUT_STATS_EN to add the n_read / truncated statistics outputs.
module mem_readout_seq #(
   parameter int NMEM      = 24,
   parameter int ADDR_W    = 6,
   parameter int RD_LAT    = 1,
   parameter int MAX_READS = 100
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start,
   input  logic [2:0]                 bx_in,
   input  logic [NMEM*(ADDR_W+1)-1:0] n_entries,
   output logic                       rd_en,
   output logic [ADDR_W-1:0]          rd_add,
   output logic [4:0]                 sel,
   output logic                       valid_out,
   output logic [2:0]                 bx_out,
   output logic                       done,
`ifdef MEM_READOUT_STATS_EN
   output logic [7:0]                 n_read,
   output logic                       truncated,
`endif
   output logic                       busy
);
   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] CNT_MAX    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CW-1:0] CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [7:0]    BUDGET_MAX = 8'(MAX_READS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Lowest set mask bit at or above lo; bit 5 of the result flags a hit.
   function automatic logic [5:0] find_from(input logic [NMEM-1:0] mask, input logic [5:0] lo);
      logic [5:0] hit;
      hit = 6'd0;
      for (int i = NMEM - 1; i >= 0; i--) begin
         if (mask[i] && (6'(i) >= lo)) begin
            hit = {1'b1, 5'(i)};
         end
      end
      return hit;
   endfunction

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q     [NMEM];
   logic [CW-1:0]     cnt_d     [NMEM];
   logic [CW-1:0]     new_cnt_s [NMEM];
   logic [NMEM-1:0]   new_mask_s, mask_q, mask_d;
   logic [2:0]        bx_q, bx_d;
   logic [4:0]        cur_mem_q, cur_mem_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [7:0]        budget_q, budget_d;
   logic [5:0]        first_s, nxt_s;
   logic              flush_tok_s;
   logic              rd_en_q, busy_q;

   logic [RD_LAT:0]   v_s, d_s;
   logic [4:0]        m_s [RD_LAT+1];
   logic [2:0]        b_s [RD_LAT+1];
   logic [RD_LAT-1:0] v_pipe_q, d_pipe_q;
   logic [4:0]        m_pipe_q [RD_LAT];
   logic [2:0]        b_pipe_q [RD_LAT];
   logic [4:0]        sel_q;
   logic              valid_q, done_q;
   logic [2:0]        bx_out_q;
`ifdef MEM_READOUT_STATS_EN
   logic              trunc_q, trunc_d;
   logic [8:0]        st_s      [RD_LAT+1];
   logic [8:0]        st_pipe_q [RD_LAT];
   logic [7:0]        n_read_q;
   logic              truncated_q;
`endif

   // Clamp incoming counts and derive the non-empty mask.
   always_comb begin
      new_mask_s = {NMEM{1'b0}};
      for (int i = 0; i < NMEM; i++) begin
         new_cnt_s[i]  = (n_entries[i*CW +: CW] > CNT_MAX) ? CNT_MAX : n_entries[i*CW +: CW];
         new_mask_s[i] = (n_entries[i*CW +: CW] != {CW{1'b0}});
      end
   end

   // Next-state logic: start always wins and restarts the walk.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      bx_d        = bx_q;
      cur_mem_d   = cur_mem_q;
      cur_addr_d  = cur_addr_q;
      budget_d    = budget_q;
      flush_tok_s = 1'b0;
`ifdef MEM_READOUT_STATS_EN
      trunc_d     = trunc_q;
`endif
      first_s     = find_from(new_mask_s, 6'd0);
      nxt_s       = find_from(mask_q, {1'b0, cur_mem_q} + 6'd1);
      if (start) begin
         cnt_d    = new_cnt_s;
         mask_d   = new_mask_s;
         bx_d     = bx_in;
         budget_d = 8'd0;
`ifdef MEM_READOUT_STATS_EN
         trunc_d  = 1'b0;
`endif
         if (first_s[5]) begin
            state_d    = READ;
            cur_mem_d  = first_s[4:0];
            cur_addr_d = {ADDR_W{1'b0}};
         end else begin
            state_d = FLUSH;
         end
      end else begin
         case (state_q)
            READ: begin
               budget_d = budget_q + 8'd1;
               if ((budget_q + 8'd1) == BUDGET_MAX) begin
                  state_d = FLUSH;
`ifdef MEM_READOUT_STATS_EN
                  trunc_d = 1'b1;
`endif
               end else if ({1'b0, cur_addr_q} == (cnt_q[cur_mem_q] - CNT_ONE)) begin
                  if (nxt_s[5]) begin
                     cur_mem_d  = nxt_s[4:0];
                     cur_addr_d = {ADDR_W{1'b0}};
                  end else begin
                     state_d = FLUSH;
                  end
               end else begin
                  cur_addr_d = cur_addr_q + ADDR_W'(1);
               end
            end
            FLUSH: begin
               flush_tok_s = 1'b1;
               state_d     = IDLE;
            end
            IDLE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Sequencer state and read-port registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         for (int i = 0; i < NMEM; i++) cnt_q[i] <= {CW{1'b0}};
         mask_q     <= {NMEM{1'b0}};
         bx_q       <= 3'd0;
         cur_mem_q  <= 5'd0;
         cur_addr_q <= {ADDR_W{1'b0}};
         budget_q   <= 8'd0;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mask_q     <= mask_d;
         bx_q       <= bx_d;
         cur_mem_q  <= cur_mem_d;
         cur_addr_q <= cur_addr_d;
         budget_q   <= budget_d;
         rd_en_q    <= (state_d == READ);
         busy_q     <= (state_d == READ);
      end
   end

   // Stage 0 is the read issued this cycle; stage k is k cycles old.
   always_comb begin
      v_s[0] = rd_en_q;
      d_s[0] = flush_tok_s;
      m_s[0] = cur_mem_q;
      b_s[0] = bx_q;
`ifdef MEM_READOUT_STATS_EN
      st_s[0] = {trunc_q, budget_q};
`endif
      for (int k = 1; k <= RD_LAT; k++) begin
         v_s[k] = v_pipe_q[k-1];
         d_s[k] = d_pipe_q[k-1];
         m_s[k] = m_pipe_q[k-1];
         b_s[k] = b_pipe_q[k-1];
`ifdef MEM_READOUT_STATS_EN
         st_s[k] = st_pipe_q[k-1];
`endif
      end
   end

   // Delay pipes and mux-aligned output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_pipe_q <= {RD_LAT{1'b0}};
         d_pipe_q <= {RD_LAT{1'b0}};
         for (int k = 0; k < RD_LAT; k++) begin
            m_pipe_q[k] <= 5'd0;
            b_pipe_q[k] <= 3'd0;
         end
         sel_q    <= 5'd0;
         valid_q  <= 1'b0;
         bx_out_q <= 3'd0;
         done_q   <= 1'b0;
      end else begin
         for (int k = 0; k < RD_LAT; k++) begin
            v_pipe_q[k] <= v_s[k];
            d_pipe_q[k] <= d_s[k];
            m_pipe_q[k] <= m_s[k];
            b_pipe_q[k] <= b_s[k];
         end
         if (v_s[RD_LAT-1]) begin
            sel_q <= m_s[RD_LAT-1];
         end
         valid_q <= v_s[RD_LAT];
         if (v_s[RD_LAT]) begin
            bx_out_q <= b_s[RD_LAT];
         end
         done_q <= d_s[RD_LAT];
      end
   end

`ifdef MEM_READOUT_STATS_EN
   // Statistics travel with the done token and are captured on the done cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         trunc_q     <= 1'b0;
         for (int k = 0; k < RD_LAT; k++) st_pipe_q[k] <= 9'd0;
         n_read_q    <= 8'd0;
         truncated_q <= 1'b0;
      end else begin
         trunc_q <= trunc_d;
         for (int k = 0; k < RD_LAT; k++) st_pipe_q[k] <= st_s[k];
         if (d_s[RD_LAT]) begin
            n_read_q    <= st_s[RD_LAT][7:0];
            truncated_q <= st_s[RD_LAT][8];
         end
      end
   end

   assign n_read    = n_read_q;
   assign truncated = truncated_q;
`endif

   assign rd_en     = rd_en_q;
   assign rd_add    = cur_addr_q;
   assign sel       = sel_q;
   assign valid_out = valid_q;
   assign bx_out    = bx_out_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule
